stopwatch_controller: RTL and testbench
=======================================

# stopwatch_controller

Sequencing controller for the stopwatch datapath. It takes debounced button and switch levels, runs the program/run/pause/done state machine, and owns the centisecond time counter and the programmable limit register. It generates the centisecond tick from the system clock. It drives the time value consumed by the display path, and hands one completed-run record per run to the leaderboard.

## Interface
Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- TICK_HZ, 100, count rate (centiseconds). DIV = CLK_HZ/TICK_HZ, which must be an integer ≥ 2.

Ports:
- clock, in, 1, system clock; all logic is on its rising edge.
- reset, in, 1, synchronous, active-high; clears all state.
- startstop, in, 1, debounced button level. A rising edge is a start/stop press.
- inc, in, 1, debounced button level. A rising edge is an increment press in PROG, or a submit press in PAUSE.
- prog, in, 1, switch level requesting program mode.
- up, in, 1, switch: 1 = count up, 0 = count down. Sampled at start.
- min, in, 1, switch: 1 = inc adds minutes, 0 = inc adds seconds.
- time_cs, out, 22, current count in centiseconds.
- limit_cs, out, 22, programmed limit = limit_min*6000 + limit_sec*100.
- state, out, 3, IDLE=0, PROG=1, RUN=2, PAUSE=3, DONE=4.
- dir_up, out, 1, direction latched at start.
- alarm, out, 1, high while in DONE; drives the speaker path.
- record_valid, out, 1, one-cycle pulse when a run completes.
- record_time, out, 22, elapsed centiseconds of the completed run. Valid with record_valid, and held until the next record.

## Operation
- Edge detect: the block registers the previous startstop and inc levels. A press is level & ~prev, and it acts in the same cycle.
- Limit register: limit_min[5:0] and limit_sec[5:0]. Reset value is 1:00 (limit_cs = 6000).
- IDLE:
  - time_cs loads (up ? 0 : limit_cs) every cycle.
  - prog=1 → PROG.
  - A startstop press → RUN, latches dir_up=up, and clears the divider. The press is ignored when up=0 and limit_cs=0.
- PROG:
  - time_cs tracks IDLE's load rule.
  - An inc press increments limit_min (min=1) or limit_sec (min=0). Each field wraps 59→0 with no carry into the other field.
  - prog=0 → IDLE.
  - startstop is ignored.
- RUN:
  - On each tick, dir_up=1 increments time_cs and dir_up=0 decrements it.
  - Up mode goes to DONE on the tick where the new value equals limit_cs. If limit_cs=0, it goes to DONE when the value reaches 359999.
  - Down mode goes to DONE on the tick where the new value is 0.
  - A startstop press → PAUSE. The press wins over a same-cycle tick, and that tick is dropped (no count change).
  - prog and inc are ignored.
- PAUSE:
  - The count and divider phase are frozen.
  - A startstop press → RUN, resuming with the divider phase retained.
  - An inc press → DONE (manual submit).
  - When startstop and inc are pressed in the same cycle, startstop wins.
- DONE:
  - alarm=1 and time_cs is held.
  - A startstop press → IDLE, which clears alarm.
  - prog is ignored until IDLE.
- Record: on every transition into DONE, record_time = dir_up ? time_cs_new : limit_cs − time_cs_new. record_valid is 1 for exactly one cycle.
- Widths: all arithmetic is 22-bit unsigned. Underflow below 0 and overflow above 359999 never occur by construction.

## Timing
- Reset values:
  - state=IDLE, time_cs=0, limit_cs=6000, dir_up=1.
  - alarm=0, record_valid=0, record_time=0.
  - Divider=0, edge registers=0.
- Press latency: the input rises in cycle n, and state/outputs update at the edge ending cycle n (visible in n+1).
- Divider:
  - Counts 0..DIV−1 only in RUN, and is cleared on IDLE→RUN.
  - A tick is the cycle with divider = DIV−1. The count updates at that edge, so the first tick after start comes DIV cycles after the start press.
- record_valid and alarm assert in the first cycle state=DONE.
- Reset mid-run, mid-pause, or in DONE: the next cycle holds reset values and the limit returns to 1:00.
- In IDLE/PROG, time_cs follows a limit or up change one cycle later.

## Test plan
(All scenarios use CLK_HZ=1000, TICK_HZ=100, so DIV=10.)
- Reset → all outputs at reset values. With up=0, time_cs=6000 one cycle after reset deasserts.
- PROG, min=0, 61 inc presses → limit_sec=1, limit_cs=6100. Then min=1, 59 presses → limit_min=0 (1+59 wraps), limit_cs=100.
- limit 0:01, up=1, start → time_cs reaches 100 at 1000 cycles. DONE, alarm=1, one-cycle record_valid with record_time=100.
- limit 1:00, up=0, start, pause after 50 ticks, wait 200 cycles, inc submit → time_cs=5950, record_time=50, state=DONE.
- RUN with a startstop press landing on a tick cycle → PAUSE with no count change. Resume → next tick after the remaining divider phase.
- up=0 with limit_cs=0 and a start press → stays IDLE. Reset asserted during RUN → IDLE and time_cs=0 next cycle.

Source files
------------

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencing controller: program/run/pause/done FSM, centisecond
// counter with its tick divider, programmable limit and completed-run record.
module stopwatch_controller #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        startstop,
    input  logic        inc,
    input  logic        prog,
    input  logic        up,
    input  logic        min,
    output logic [21:0] time_cs,
    output logic [21:0] limit_cs,
    output logic [2:0]  state,
    output logic        dir_up,
    output logic        alarm,
    output logic        record_valid,
    output logic [21:0] record_time
);

    localparam int          DIV    = CLK_HZ / TICK_HZ;
    localparam int          DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [21:0] MAX_CS = 22'd359999;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PROG  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [21:0]        time_r, time_s;
    logic [5:0]         lim_min_r, lim_min_s;
    logic [5:0]         lim_sec_r, lim_sec_s;
    logic               dir_r, dir_s;
    logic [DIV_W-1:0]   div_r, div_s;
    logic               ss_prev_r, inc_prev_r;
    logic               rec_valid_r, rec_valid_s;
    logic [21:0]        rec_time_r, rec_time_s;
    logic               alarm_r, alarm_s;

    logic               ss_press_s, inc_press_s, tick_s, hit_s;
    logic [21:0]        limit_s, load_s, step_s;

    // Minute and second fields each wrap 59 -> 0 without carrying
    function automatic logic [5:0] wrap_inc(input logic [5:0] v);
        if (v == 6'd59) begin
            return 6'd0;
        end else begin
            return v + 6'd1;
        end
    endfunction

    assign ss_press_s  = startstop & ~ss_prev_r;
    assign inc_press_s = inc & ~inc_prev_r;
    assign limit_s     = 22'(lim_min_r) * 22'd6000 + 22'(lim_sec_r) * 22'd100;
    assign load_s      = up ? 22'd0 : limit_s;
    assign tick_s      = (div_r == DIV_W'(DIV - 1));
    assign step_s      = dir_r ? (time_r + 22'd1) : (time_r - 22'd1);
    assign hit_s       = dir_r ? ((limit_s == 22'd0) ? (step_s == MAX_CS) : (step_s == limit_s))
                               : (step_s == 22'd0);

    // Next-state and datapath decisions for every state
    always_comb begin
        state_s     = state_r;
        time_s      = time_r;
        lim_min_s   = lim_min_r;
        lim_sec_s   = lim_sec_r;
        dir_s       = dir_r;
        div_s       = div_r;
        rec_valid_s = 1'b0;
        rec_time_s  = rec_time_r;
        case (state_r)
            ST_IDLE: begin
                time_s = load_s;
                if (prog) begin
                    state_s = ST_PROG;
                end else if (ss_press_s && (up || (limit_s != 22'd0))) begin
                    state_s = ST_RUN;
                    dir_s   = up;
                    div_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PROG: begin
                time_s = load_s;
                if (inc_press_s && min) begin
                    lim_min_s = wrap_inc(lim_min_r);
                end else if (inc_press_s) begin
                    lim_sec_s = wrap_inc(lim_sec_r);
                end else begin
                    lim_min_s = lim_min_r;
                end
                if (!prog) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_PROG;
                end
            end
            ST_RUN: begin
                // A stop press freezes the divider and drops any coincident tick
                if (ss_press_s) begin
                    state_s = ST_PAUSE;
                end else if (tick_s) begin
                    div_s  = '0;
                    time_s = step_s;
                    if (hit_s) begin
                        state_s     = ST_DONE;
                        rec_valid_s = 1'b1;
                        rec_time_s  = dir_r ? step_s : (limit_s - step_s);
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    div_s = div_r + DIV_W'(1);
                end
            end
            ST_PAUSE: begin
                if (ss_press_s) begin
                    state_s = ST_RUN;
                end else if (inc_press_s) begin
                    state_s     = ST_DONE;
                    rec_valid_s = 1'b1;
                    rec_time_s  = dir_r ? time_r : (limit_s - time_r);
                end else begin
                    state_s = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (ss_press_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        alarm_s = (state_s == ST_DONE);
    end

    // Register update with synchronous reset to the 1:00 count-up idle state
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            time_r      <= 22'd0;
            lim_min_r   <= 6'd1;
            lim_sec_r   <= 6'd0;
            dir_r       <= 1'b1;
            div_r       <= '0;
            ss_prev_r   <= 1'b0;
            inc_prev_r  <= 1'b0;
            rec_valid_r <= 1'b0;
            rec_time_r  <= 22'd0;
            alarm_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            time_r      <= time_s;
            lim_min_r   <= lim_min_s;
            lim_sec_r   <= lim_sec_s;
            dir_r       <= dir_s;
            div_r       <= div_s;
            ss_prev_r   <= startstop;
            inc_prev_r  <= inc;
            rec_valid_r <= rec_valid_s;
            rec_time_r  <= rec_time_s;
            alarm_r     <= alarm_s;
        end
    end

    assign time_cs      = time_r;
    assign limit_cs     = limit_s;
    assign state        = state_r;
    assign dir_up       = dir_r;
    assign alarm        = alarm_r;
    assign record_valid = rec_valid_r;
    assign record_time  = rec_time_r;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Bench for stopwatch_controller: vector table, directed corner sequences and a
// randomized run against a behavioural model, with DIV = 10.
module tb_stopwatch_controller;

    localparam int DIV = 10;

    logic        clock = 1'b0;
    logic        reset, startstop, inc, prog, up, min;
    logic [21:0] time_cs, limit_cs, record_time;
    logic [2:0]  state;
    logic        dir_up, alarm, record_valid;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_controller #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
        .clock(clock), .reset(reset), .startstop(startstop), .inc(inc),
        .prog(prog), .up(up), .min(min), .time_cs(time_cs), .limit_cs(limit_cs),
        .state(state), .dir_up(dir_up), .alarm(alarm), .record_valid(record_valid),
        .record_time(record_time)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic ss, inc, prog, up, min;
        int   st, tm, lim, rv, al;
    } vec_t;
    vec_t vecs[15];

    // Behavioural model: minutes/seconds, elapsed ticks and run-cycle phase
    int m_state, m_time, m_lmin, m_lsec, m_dir, m_rc, m_el, m_rv, m_rt;
    bit m_pss, m_pinc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press_inc();
        inc = 1'b1;
        tick();
        inc = 1'b0;
        tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_time"}, 32'(time_cs), 32'd0);
        check({tag, "_limit"}, 32'(limit_cs), 32'd6000);
        check({tag, "_dir"}, 32'(dir_up), 32'd1);
        check({tag, "_alarm"}, 32'(alarm), 32'd0);
        check({tag, "_rv"}, 32'(record_valid), 32'd0);
        check({tag, "_rt"}, 32'(record_time), 32'd0);
    endtask

    task automatic model_step();
        int  lim, ns, nt, nmin, nsec, ndir, nrc, nel, nrv, nrt, target;
        bit  sp, ip;
        lim  = m_lmin * 6000 + m_lsec * 100;
        sp   = startstop && !m_pss;
        ip   = inc && !m_pinc;
        ns = m_state; nt = m_time; nmin = m_lmin; nsec = m_lsec; ndir = m_dir;
        nrc = m_rc; nel = m_el; nrv = 0; nrt = m_rt;
        if (reset) begin
            ns = 0; nt = 0; nmin = 1; nsec = 0; ndir = 1; nrc = 0; nel = 0; nrt = 0;
        end else if (m_state == 0 || m_state == 1) begin
            nt = up ? 0 : lim;
            if (m_state == 1) begin
                if (ip && min) nmin = (m_lmin + 1) % 60;
                if (ip && !min) nsec = (m_lsec + 1) % 60;
                if (!prog) ns = 0;
            end else if (prog) begin
                ns = 1;
            end else if (sp && (up || lim != 0)) begin
                ns = 2; ndir = up; nrc = 0; nel = 0;
            end
        end else if (m_state == 2) begin
            if (sp) begin
                ns = 3;
            end else begin
                nrc = m_rc + 1;
                if (nrc % DIV == 0) begin
                    nt     = m_dir ? m_time + 1 : m_time - 1;
                    nel    = m_el + 1;
                    target = m_dir ? ((lim == 0) ? 359999 : lim) : 0;
                    if (nt == target) begin
                        ns = 4; nrv = 1; nrt = nel;
                    end
                end
            end
        end else if (m_state == 3) begin
            if (sp) ns = 2;
            else if (ip) begin ns = 4; nrv = 1; nrt = m_el; end
        end else begin
            if (sp) ns = 0;
        end
        m_state = ns; m_time = nt; m_lmin = nmin; m_lsec = nsec; m_dir = ndir;
        m_rc = nrc; m_el = nel; m_rv = nrv; m_rt = nrt;
        m_pss  = reset ? 1'b0 : startstop;
        m_pinc = reset ? 1'b0 : inc;
    endtask

    initial begin
        reset = 1'b1; startstop = 1'b0; inc = 1'b0; prog = 1'b0; up = 1'b1; min = 1'b0;
        tick();
        tick();
        check_reset_values("init");
        reset = 1'b0;

        // ss inc prog up min | state time limit rv alarm
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 6000,  6000,  0, 0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 6000,  6000,  0, 0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 6000,  6100,  0, 0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 6100,  6100,  0, 0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 6100,  6100,  0, 0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 6100,  12100, 0, 0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 12100, 12100, 0, 0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0,     12100, 0, 0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 0,     12100, 0, 0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 0,     12100, 0, 0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2, 0,     12100, 0, 0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3, 0,     12100, 0, 0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4, 0,     12100, 1, 1};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4, 0,     12100, 0, 1};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0,     12100, 0, 0};
        for (int i = 0; i < 15; i++) begin
            startstop = vecs[i].ss; inc = vecs[i].inc; prog = vecs[i].prog;
            up = vecs[i].up; min = vecs[i].min;
            tick();
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("vec%0d_time", i), 32'(time_cs), 32'(vecs[i].tm));
            check($sformatf("vec%0d_limit", i), 32'(limit_cs), 32'(vecs[i].lim));
            check($sformatf("vec%0d_rv", i), 32'(record_valid), 32'(vecs[i].rv));
            check($sformatf("vec%0d_alarm", i), 32'(alarm), 32'(vecs[i].al));
        end
        startstop = 1'b0; inc = 1'b0; prog = 1'b0;

        // Limit programming with per-field wrap
        reset = 1'b1; tick(); reset = 1'b0;
        prog = 1'b1; min = 1'b0; tick();
        for (int i = 0; i < 61; i++) press_inc();
        check("prog_sec_wrap", 32'(limit_cs), 32'd6100);
        min = 1'b1;
        for (int i = 0; i < 59; i++) press_inc();
        check("prog_min_wrap", 32'(limit_cs), 32'd100);
        prog = 1'b0; tick();
        check("prog_exit", 32'(state), 32'd0);

        // Count up to 0:01 and measure latency from the start press
        begin
            int c;
            up = 1'b1; tick();
            startstop = 1'b1; tick(); startstop = 1'b0;
            c = 0;
            for (int k = 1; k <= 1100; k++) begin
                tick();
                c = k;
                if (state == 3'd4) break;
            end
            check("up_done_cycles", 32'(c), 32'd1000);
            check("up_done_time", 32'(time_cs), 32'd100);
            check("up_done_rv", 32'(record_valid), 32'd1);
            check("up_done_rt", 32'(record_time), 32'd100);
            check("up_done_alarm", 32'(alarm), 32'd1);
            tick();
            check("up_rv_pulse", 32'(record_valid), 32'd0);
            check("up_rt_hold", 32'(record_time), 32'd100);
            check("up_time_hold", 32'(time_cs), 32'd100);
        end

        // Reset while in DONE, then down-mode load
        reset = 1'b1; tick(); reset = 1'b0;
        check_reset_values("rst_done");
        up = 1'b0; tick();
        check("down_load", 32'(time_cs), 32'd6000);

        // Down count, pause, manual submit
        startstop = 1'b1; tick(); startstop = 1'b0;
        repeat (500) tick();
        check("down_50", 32'(time_cs), 32'd5950);
        startstop = 1'b1; tick(); startstop = 1'b0;
        repeat (200) tick();
        check("pause_state", 32'(state), 32'd3);
        check("pause_time", 32'(time_cs), 32'd5950);
        inc = 1'b1; tick(); inc = 1'b0;
        check("submit_state", 32'(state), 32'd4);
        check("submit_rv", 32'(record_valid), 32'd1);
        check("submit_rt", 32'(record_time), 32'd50);
        check("submit_time", 32'(time_cs), 32'd5950);

        // Stop press on a tick cycle drops the tick; resume keeps the phase
        startstop = 1'b1; tick(); startstop = 1'b0;
        check("done_exit", 32'(state), 32'd0);
        tick();
        startstop = 1'b1; tick(); startstop = 1'b0;
        repeat (9) tick();
        startstop = 1'b1; tick(); startstop = 1'b0;
        check("tickpress_state", 32'(state), 32'd3);
        check("tickpress_time", 32'(time_cs), 32'd6000);
        tick();
        startstop = 1'b1; tick(); startstop = 1'b0;
        check("resume_state", 32'(state), 32'd2);
        check("resume_time", 32'(time_cs), 32'd6000);
        tick();
        check("resume_first_tick", 32'(time_cs), 32'd5999);
        repeat (10) tick();
        check("resume_next_tick", 32'(time_cs), 32'd5998);

        // Reset mid-run in down mode
        reset = 1'b1; tick(); reset = 1'b0;
        check_reset_values("rst_run");

        // Zero limit blocks a down-mode start; up-mode run then reset
        prog = 1'b1; min = 1'b1; tick();
        for (int i = 0; i < 59; i++) press_inc();
        check("zero_limit", 32'(limit_cs), 32'd0);
        prog = 1'b0; up = 1'b0; tick();
        startstop = 1'b1; tick(); startstop = 1'b0;
        check("zero_start_ignored", 32'(state), 32'd0);
        tick();
        up = 1'b1; startstop = 1'b1; tick(); startstop = 1'b0;
        check("zero_up_start", 32'(state), 32'd2);
        repeat (25) tick();
        check("zero_up_count", 32'(time_cs), 32'd2);
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst_run2_state", 32'(state), 32'd0);
        check("rst_run2_time", 32'(time_cs), 32'd0);
        check("rst_run2_limit", 32'(limit_cs), 32'd6000);

        // Randomized run against the model
        reset = 1'b1; startstop = 1'b0; inc = 1'b0; prog = 1'b0; up = 1'b1; min = 1'b0;
        model_step();
        tick();
        for (int cyc = 0; cyc < 6000; cyc++) begin
            reset = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 29) == 0) startstop = ~startstop;
            if ($urandom_range(0, 19) == 0) inc = ~inc;
            if ($urandom_range(0, 149) == 0) prog = ~prog;
            if ($urandom_range(0, 59) == 0) up = ~up;
            min = 1'($urandom_range(0, 1));
            model_step();
            tick();
            check("rnd_state", 32'(state), 32'(m_state));
            check("rnd_time", 32'(time_cs), 32'(m_time));
            check("rnd_limit", 32'(limit_cs), 32'(m_lmin * 6000 + m_lsec * 100));
            check("rnd_dir", 32'(dir_up), 32'(m_dir));
            check("rnd_alarm", 32'(alarm), (m_state == 4) ? 32'd1 : 32'd0);
            check("rnd_rv", 32'(record_valid), 32'(m_rv));
            check("rnd_rt", 32'(record_time), 32'(m_rt));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
